// File: rtl/seq_mult_arb_if.sv
// Requester/multiplier bundle for seq_mult_arb. The arbiter connects through
// the slave modport; the requester/multiplier side connects through master.
interface seq_mult_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 16
);
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*AW-1:0] i_req_a;
  logic [NREQ*AW-1:0] i_req_b;
  logic [NREQ-1:0]    o_req_ready;
  logic [AW-1:0]      o_mul_a;
  logic [AW-1:0]      o_mul_b;
  logic               o_mul_valid;
  logic [AW-1:0]      i_mul_data;
  logic               i_mul_valid;
  logic               o_resp_valid;
  logic [IDW-1:0]     o_resp_id;
  logic [AW-1:0]      o_resp_data;
  logic               o_resp_err;
  logic               o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_mul_data, i_mul_valid,
    output o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
           o_resp_valid, o_resp_id, o_resp_data, o_resp_err, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_mul_data, i_mul_valid,
    input  o_req_ready, o_mul_a, o_mul_b, o_mul_valid,
           o_resp_valid, o_resp_id, o_resp_data, o_resp_err, o_busy
  );
endinterface

// File: rtl/seq_mult_arb.sv
// Round-robin arbiter/sequencer sharing one multiplier among NREQ requesters.
// Optional WAIT watchdog enabled by defining SEQ_MULT_ARB_TIMEOUT_EN.
module seq_mult_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 15
) (
  input  logic          clk,
  input  logic          rst,
  seq_mult_arb_if.slave bus
);
  // Operand width shared with seq_definitions.v (alu_width).
  localparam int alu_width = 16;

  if (NREQ < 2 || NREQ > 8 || (2 ** IDW) < NREQ || TMO < 1) begin : g_bad_cfg
    $error("seq_mult_arb: invalid NREQ/IDW/TMO combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] next_ptr;
  logic           found;

  // First requesting index at or above rr_ptr, wrapping modulo NREQ.
  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.i_req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign next_ptr = (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);

`ifdef SEQ_MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
`endif

  // Strobes are registered from the current state, so each one lags its
  // state by a cycle: grant, issue, wait, respond land on cycles 1, 2, 3+, 4+.
  // NOTE: async reset clears every state and output register, including operand/data holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      id_q             <= '0;
      bus.o_req_ready  <= '0;
      bus.o_mul_a      <= '0;
      bus.o_mul_b      <= '0;
      bus.o_mul_valid  <= 1'b0;
      bus.o_resp_valid <= 1'b0;
      bus.o_resp_id    <= '0;
      bus.o_resp_data  <= '0;
      bus.o_busy       <= 1'b0;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
      wait_cnt         <= '0;
      err_q            <= 1'b0;
      bus.o_resp_err   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      bus.o_req_ready  <= '0;
      bus.o_mul_valid  <= (state == ISSUE);
      bus.o_resp_valid <= (state == RESP);
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
      bus.o_resp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            bus.o_req_ready <= NREQ'(1) << winner;
            bus.o_mul_a     <= bus.i_req_a[int'(winner) * alu_width +: alu_width];
            bus.o_mul_b     <= bus.i_req_b[int'(winner) * alu_width +: alu_width];
            id_q            <= winner;
            rr_ptr          <= next_ptr;
            bus.o_busy      <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.i_mul_valid) begin
            bus.o_resp_data <= bus.i_mul_data;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
            err_q           <= 1'b0;
`endif
            state           <= RESP;
          end
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
          // Reaching TMO idle cycles abandons the multiplier result.
          else if (wait_cnt == CW'(TMO - 1)) begin
            bus.o_resp_data <= '0;
            err_q           <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        RESP: begin
          bus.o_resp_id <= id_q;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
          bus.o_resp_err <= err_q;
`endif
          bus.o_busy    <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_MULT_ARB_TIMEOUT_EN
  assign bus.o_resp_err = 1'b0;
`endif

endmodule
